// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the round-robin TX arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [8*NUM_REQ-1:0] i_data;
    logic [NUM_REQ-1:0]   o_ack;
    logic [3:0]           o_grant;
    logic                 o_busy;
    logic                 o_err;
    logic                 o_tx_start;
    logic [7:0]           o_tx_data;
    logic                 i_tx_busy;

    modport slave (
        input  i_req, i_data, i_tx_busy,
        output o_ack, o_grant, o_busy, o_err, o_tx_start, o_tx_data
    );

    modport master (
        output i_req, i_data, i_tx_busy,
        input  o_ack, o_grant, o_busy, o_err, o_tx_start, o_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Optional feature UART_ARB_TAG_EN: prefix each byte with tag {4'hA, grantee}.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              i_rst,
    uart_tx_arbiter_if.slave  bus
);
`ifdef UART_ARB_TAG_EN
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, TAG_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
`endif

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [3:0]           grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 start_q, start_d;
    logic [7:0]           data_q, data_d;
    logic [7:0]           cnt_q, cnt_d;
`ifdef UART_ARB_TAG_EN
    logic [7:0]           byte_q, byte_d;
    logic                 tagp_q, tagp_d;
`endif

    logic                 found;
    logic [3:0]           win;
    logic [7:0]           win_byte;
    logic [NUM_REQ-1:0]   win_oh;

    // Two passes give the round-robin order: above the pointer first, then wrap.
    always_comb begin
        found    = 1'b0;
        win      = grant_q;
        win_byte = 8'h00;
        win_oh   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.i_req[j] && j > int'(grant_q)) begin
                found    = 1'b1;
                win      = 4'(j);
                win_byte = bus.i_data[8*j +: 8];
                win_oh   = '0;
                win_oh[j] = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && bus.i_req[j] && j <= int'(grant_q)) begin
                found    = 1'b1;
                win      = 4'(j);
                win_byte = bus.i_data[8*j +: 8];
                win_oh   = '0;
                win_oh[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        grant_d = grant_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        start_d = start_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef UART_ARB_TAG_EN
        byte_d  = byte_q;
        tagp_d  = tagp_q;
`endif
        case (state_q)
            IDLE: begin
                if (found && !bus.i_tx_busy) begin
                    ack_d   = win_oh;
                    grant_d = win;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = WAIT_BUSY;
`ifdef UART_ARB_TAG_EN
                    data_d  = {4'hA, win};
                    byte_d  = win_byte;
                    tagp_d  = 1'b1;
`else
                    data_d  = win_byte;
`endif
                end
            end
            WAIT_BUSY: begin
                if (bus.i_tx_busy) begin
                    start_d = 1'b0;
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    // Ack was already given, so a timeout simply drops the byte.
                    if (cnt_d == 8'(BUSY_TIMEOUT)) begin
                        start_d = 1'b0;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
`ifdef UART_ARB_TAG_EN
                        tagp_d  = 1'b0;
`endif
                    end
                end
            end
            WAIT_DONE: begin
                if (!bus.i_tx_busy) begin
`ifdef UART_ARB_TAG_EN
                    if (tagp_q) begin
                        tagp_d  = 1'b0;
                        state_d = TAG_WAIT;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
`else
                    busy_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            TAG_WAIT: begin
                data_d  = byte_q;
                start_d = 1'b1;
                cnt_d   = 8'd0;
                state_d = WAIT_BUSY;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ack_q   <= '0;
            grant_q <= 4'(NUM_REQ - 1);
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            cnt_q   <= 8'd0;
`ifdef UART_ARB_TAG_EN
            byte_q  <= 8'h00;
            tagp_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            start_q <= start_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef UART_ARB_TAG_EN
            byte_q  <= byte_d;
            tagp_q  <= tagp_d;
`endif
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_grant    = grant_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_err      = err_q;
    assign bus.o_tx_start = start_q;
    assign bus.o_tx_data  = data_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a stub uart_tx (busy 1 cycle after
// start, high 10 cycles); honours UART_ARB_TAG_EN when defined.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int BT      = 16;

    logic clk = 1'b0;
    logic i_rst;
    int   vecs = 0;
    int   miss = 0;

    logic       model_en = 1'b1;
    logic       mbusy    = 1'b0;
    logic [3:0] mcnt     = 4'd0;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .BUSY_TIMEOUT(BT)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Stub uart_tx: no reset, so a frame in flight survives an arbiter reset.
    always @(posedge clk) begin
        if (!mbusy && bus.o_tx_start && model_en) begin
            mbusy <= 1'b1;
            mcnt  <= 4'd9;
        end else if (mbusy) begin
            if (mcnt == 4'd0) mbusy <= 1'b0;
            else              mcnt  <= mcnt - 4'd1;
        end
    end
    assign bus.i_tx_busy = mbusy;

    function automatic logic [7:0] exp_first(input int k);
        logic [7:0] b;
        b = bus.i_data[8*k +: 8];
`ifdef UART_ARB_TAG_EN
        b = {4'hA, 4'(k)};
`endif
        return b;
    endfunction

    task automatic wait_ack(output int idx, output bit ok, output bit err_seen);
        idx = -1; ok = 1'b0; err_seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.o_err) err_seen = 1'b1;
            if (|bus.o_ack) begin
                for (int k = 0; k < NUM_REQ; k++) if (bus.o_ack[k]) idx = k;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        bus.i_req = '0;
        repeat (3) @(negedge clk);
        vecs++;
        if ({bus.o_ack, bus.o_grant, bus.o_busy, bus.o_err, bus.o_tx_start, bus.o_tx_data}
            !== {4'h0, 4'h3, 3'b000, 8'h00}) begin
            miss++;
            $display("FAIL reset_state: got ack=%b grant=%0d busy=%b err=%b start=%b data=%h",
                     bus.o_ack, bus.o_grant, bus.o_busy, bus.o_err, bus.o_tx_start, bus.o_tx_data);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_all_req();
        int order[5] = '{0, 1, 2, 3, 0};
        int idx; bit ok, es;
        bus.i_req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack(idx, ok, es);
            vecs++;
            if (!ok || idx != order[f] || bus.o_grant != 4'(order[f]) ||
                $countones(bus.o_ack) != 1 || bus.o_tx_start !== 1'b1 ||
                bus.o_tx_data !== exp_first(order[f])) begin
                miss++;
                $display("FAIL all_req_grant%0d: got ok=%b idx=%0d grant=%0d ack=%b start=%b data=%h, want idx=%0d data=%h",
                         f, ok, idx, bus.o_grant, bus.o_ack, bus.o_tx_start, bus.o_tx_data,
                         order[f], exp_first(order[f]));
            end
            @(negedge clk);
            vecs++;
            if (bus.o_ack !== 4'b0000) begin
                miss++;
                $display("FAIL ack_pulse%0d: got ack=%b, want 0000", f, bus.o_ack);
            end
        end
    endtask

    task automatic test_lone_req();
        int idx; bit ok, es;
        bus.i_req = 4'b0100;
        for (int f = 0; f < 3; f++) begin
            wait_ack(idx, ok, es);
            vecs++;
            if (!ok || idx != 2 || es || bus.o_grant != 4'd2 || bus.o_tx_data !== exp_first(2)) begin
                miss++;
                $display("FAIL lone_req%0d: got ok=%b idx=%0d err=%b grant=%0d data=%h, want idx=2 err=0 data=%h",
                         f, ok, idx, es, bus.o_grant, bus.o_tx_data, exp_first(2));
            end
        end
        bus.i_req = '0;
    endtask

    task automatic test_timeout();
        int idx, hi; bit ok, es;
        model_en = 1'b0;
        bus.i_req = 4'b0001;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        vecs++;
        if (!ok || idx != 0) begin
            miss++;
            $display("FAIL timeout_grant: got ok=%b idx=%0d, want idx=0", ok, idx);
        end
        hi = 0;
        for (int c = 0; c < 300 && bus.o_tx_start; c++) begin
            hi++;
            @(negedge clk);
        end
        vecs++;
        if (hi != BT) begin
            miss++;
            $display("FAIL timeout_start_len: got %0d cycles, want %0d", hi, BT);
        end
        vecs++;
        if ({bus.o_err, bus.o_busy, bus.o_tx_start} !== 3'b100) begin
            miss++;
            $display("FAIL timeout_err: got err=%b busy=%b start=%b, want 1 0 0",
                     bus.o_err, bus.o_busy, bus.o_tx_start);
        end
        @(negedge clk);
        vecs++;
        if (bus.o_err !== 1'b0) begin
            miss++;
            $display("FAIL timeout_err_pulse: got err=%b, want 0", bus.o_err);
        end
        model_en = 1'b1;
        bus.i_req = 4'b0010;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok || idx != 1 || {bus.o_tx_start, bus.o_err, bus.o_busy} !== 3'b001) begin
            miss++;
            $display("FAIL timeout_recover: got ok=%b idx=%0d start=%b err=%b busy=%b, want idx=1 0 0 1",
                     ok, idx, bus.o_tx_start, bus.o_err, bus.o_busy);
        end
    endtask

    task automatic test_mid_reset();
        int idx; bit ok, es;
        bus.i_req = 4'b0100;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        repeat (4) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        vecs++;
        if (!mbusy || {bus.o_ack, bus.o_grant, bus.o_busy, bus.o_err, bus.o_tx_start, bus.o_tx_data}
            !== {4'h0, 4'h3, 3'b000, 8'h00}) begin
            miss++;
            $display("FAIL midreset_state: got mbusy=%b ack=%b grant=%0d busy=%b err=%b start=%b data=%h",
                     mbusy, bus.o_ack, bus.o_grant, bus.o_busy, bus.o_err, bus.o_tx_start, bus.o_tx_data);
        end
        i_rst = 1'b0;
        bus.i_req = 4'b1111;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        vecs++;
        if (!ok || idx != 0 || mbusy !== 1'b0) begin
            miss++;
            $display("FAIL midreset_regrant: got ok=%b idx=%0d mbusy=%b, want idx=0 mbusy=0",
                     ok, idx, mbusy);
        end
    endtask

    task automatic test_wrap();
        int idx; bit ok, es;
        bus.i_req = 4'b0010;
        wait_ack(idx, ok, es);
        bus.i_req = 4'b1001;
        wait_ack(idx, ok, es);
        vecs++;
        if (!ok || idx != 3) begin
            miss++;
            $display("FAIL wrap_first: got ok=%b idx=%0d, want 3", ok, idx);
        end
        bus.i_req = 4'b0001;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        vecs++;
        if (!ok || idx != 0) begin
            miss++;
            $display("FAIL wrap_second: got ok=%b idx=%0d, want 0", ok, idx);
        end
    endtask

`ifdef UART_ARB_TAG_EN
    task automatic test_tag();
        int idx, acks; bit ok, es, seen, prev;
        logic [7:0] second;
        bus.i_data[23:16] = 8'h33;
        bus.i_req = 4'b0100;
        wait_ack(idx, ok, es);
        bus.i_req = '0;
        vecs++;
        if (!ok || idx != 2 || bus.o_tx_data !== 8'hA2) begin
            miss++;
            $display("FAIL tag_first: got ok=%b idx=%0d data=%h, want idx=2 data=a2", ok, idx, bus.o_tx_data);
        end
        acks = 0; seen = 1'b0; second = 8'h00; prev = bus.o_tx_start;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (|bus.o_ack) acks++;
            if (bus.o_tx_start && !prev) begin seen = 1'b1; second = bus.o_tx_data; end
            prev = bus.o_tx_start;
        end
        vecs++;
        if (!seen || second !== 8'h33 || acks != 0 || bus.o_busy !== 1'b1) begin
            miss++;
            $display("FAIL tag_second: got seen=%b data=%h extra_acks=%0d busy=%b, want data=33 acks=0 busy=1",
                     seen, second, acks, bus.o_busy);
        end
    endtask
`endif

    initial begin
        bus.i_data = {8'hC3, 8'h5A, 8'hC1, 8'hC0};
        bus.i_req  = '0;
        i_rst      = 1'b1;
        test_reset();
        test_all_req();
        test_lone_req();
        test_timeout();
        test_mid_reset();
        test_wrap();
`ifdef UART_ARB_TAG_EN
        test_tag();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
